// File: rtl/reverb_config_sequencer.sv
// reverb_config_sequencer: shadow/active tau+gain bank for reverberator_core, tick-aligned commit.
// Latency: commit -> write rise = wait for next sample_tick + 2 cycles; write held WRITE_HOLD cycles.
// Backpressure: cfg_ready only in IDLE; commits outside IDLE merge into one pending commit.
// Optional feature macro: REVERB_CFG_TIMEOUT_EN (WAIT_TICK timeout, err_timeout flag).

`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 2048
`endif

module reverb_config_sequencer #(
  parameter int WIDTH          = 24,
  parameter int MAXDELAY       = `MAX_FILTER_FIFO_LENGTH,
  parameter int WRITE_HOLD     = 4,
`ifdef REVERB_CFG_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 4096,
`endif
  localparam int WORD          = WIDTH + `FIXED_POINT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [3:0]             cfg_addr,
  input  logic signed [WORD-1:0] cfg_data,
  input  logic                   commit,
  input  logic                   sample_tick,
  input  logic                   err_clear,
  output logic signed [WORD-1:0] tau_out  [6],
  output logic signed [WORD-1:0] gain_out [7],
  output logic                   write,
  output logic                   busy,
  output logic                   err_clamp,
  output logic                   err_addr,
  output logic                   err_timeout
);

  localparam logic signed [WORD-1:0] TAU_MIN   = WORD'(1);
  localparam logic signed [WORD-1:0] TAU_MAX   = WORD'(MAXDELAY);
  localparam logic signed [WORD-1:0] GAIN_ZERO = '0;
  localparam logic signed [WORD-1:0] GAIN_ONE  = WORD'(1 << `FIXED_POINT);
  localparam int                     HOLD_W    = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;
  localparam logic [HOLD_W-1:0]      HOLD_LOAD = HOLD_W'(WRITE_HOLD - 1);

  typedef enum logic [1:0] {IDLE, WAIT_TICK, APPLY, PULSE} state_t;

  state_t                   state_q;
  logic                     pending_q;
  logic                     write_q;
  logic [HOLD_W-1:0]        hold_cnt_q;
  logic signed [WORD-1:0]   tau_sh_q   [6];
  logic signed [WORD-1:0]   gain_sh_q  [7];
  logic signed [WORD-1:0]   tau_act_q  [6];
  logic signed [WORD-1:0]   gain_act_q [7];
  logic                     err_clamp_q;
  logic                     err_addr_q;

  logic signed [WORD-1:0]   tau_d;
  logic signed [WORD-1:0]   gain_d;
  logic                     tau_clipped;
  logic                     gain_clipped;
  logic                     wr_fire;
  logic                     addr_is_tau;
  logic                     addr_is_gain;
  logic                     clamp_evt;
  logic                     addr_evt;
  logic                     apply_go;

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign write     = write_q;
  assign tau_out   = tau_act_q;
  assign gain_out  = gain_act_q;
  assign err_clamp = err_clamp_q;
  assign err_addr  = err_addr_q;

  assign wr_fire      = cfg_valid && cfg_ready;
  assign addr_is_tau  = (cfg_addr <= 4'd5);
  assign addr_is_gain = (cfg_addr >= 4'd6) && (cfg_addr <= 4'd12);
  assign clamp_evt    = wr_fire && ((addr_is_tau && tau_clipped) || (addr_is_gain && gain_clipped));
  assign addr_evt     = wr_fire && !addr_is_tau && !addr_is_gain;

  // Saturate incoming data into the legal tau and gain ranges (signed compare).
  always_comb begin
    tau_d        = cfg_data;
    gain_d       = cfg_data;
    tau_clipped  = 1'b0;
    gain_clipped = 1'b0;
    if (cfg_data < TAU_MIN) begin
      tau_d       = TAU_MIN;
      tau_clipped = 1'b1;
    end else if (cfg_data > TAU_MAX) begin
      tau_d       = TAU_MAX;
      tau_clipped = 1'b1;
    end
    if (cfg_data < GAIN_ZERO) begin
      gain_d       = GAIN_ZERO;
      gain_clipped = 1'b1;
    end else if (cfg_data > GAIN_ONE) begin
      gain_d       = GAIN_ONE;
      gain_clipped = 1'b1;
    end
  end

  // Shadow bank: accepted host writes land here; only writable while cfg_ready is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 6; i++) tau_sh_q[i]  <= TAU_MIN;
      for (int i = 0; i < 7; i++) gain_sh_q[i] <= GAIN_ZERO;
    end else if (wr_fire) begin
      for (int i = 0; i < 6; i++)
        if (cfg_addr == 4'(i)) tau_sh_q[i] <= tau_d;
      for (int i = 0; i < 7; i++)
        if (cfg_addr == 4'(i + 6)) gain_sh_q[i] <= gain_d;
    end
  end

  // Sticky error flags; a new event in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_clamp_q <= 1'b0;
      err_addr_q  <= 1'b0;
    end else begin
      err_clamp_q <= (err_clamp_q && !err_clear) || clamp_evt;
      err_addr_q  <= (err_addr_q  && !err_clear) || addr_evt;
    end
  end

`ifdef REVERB_CFG_TIMEOUT_EN
  localparam int            TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            to_expired;
  logic            err_timeout_q;

  assign to_expired  = (state_q == WAIT_TICK) && !sample_tick && (to_cnt_q == TO_LAST);
  assign apply_go    = sample_tick || to_expired;
  assign err_timeout = err_timeout_q;

  // Count tickless cycles in WAIT_TICK; restart whenever WAIT_TICK is left or not occupied.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      to_cnt_q      <= ((state_q == WAIT_TICK) && !apply_go) ? to_cnt_q + TO_W'(1) : '0;
      err_timeout_q <= (err_timeout_q && !err_clear) || to_expired;
    end
  end
`else
  assign apply_go    = sample_tick;
  assign err_timeout = 1'b0;
`endif

  // Commit sequencer: wait for a tick, load the active bank, then hold write for WRITE_HOLD cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      write_q    <= 1'b0;
      hold_cnt_q <= '0;
      for (int i = 0; i < 6; i++) tau_act_q[i]  <= TAU_MIN;
      for (int i = 0; i < 7; i++) gain_act_q[i] <= GAIN_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          // A queued commit re-enters WAIT_TICK after one IDLE cycle so the host gets a write slot.
          if (commit || pending_q) begin
            state_q   <= WAIT_TICK;
            pending_q <= 1'b0;
          end
        end
        WAIT_TICK: begin
          if (commit) pending_q <= 1'b1;
          if (apply_go) begin
            state_q    <= APPLY;
            tau_act_q  <= tau_sh_q;
            gain_act_q <= gain_sh_q;
          end
        end
        APPLY: begin
          // Active data has been stable for a full cycle before write rises.
          if (commit) pending_q <= 1'b1;
          state_q    <= PULSE;
          write_q    <= 1'b1;
          hold_cnt_q <= HOLD_LOAD;
        end
        PULSE: begin
          if (commit) pending_q <= 1'b1;
          if (hold_cnt_q == '0) begin
            state_q <= IDLE;
            write_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reverb_config_sequencer.sv
// tb_reverb_config_sequencer: directed stimulus for reverb_config_sequencer with hand-computed expectations.
// Latency: inputs driven and outputs sampled on the falling edge, one rising edge apart.
// Backpressure: host writes are held until cfg_ready is observed high.

`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 2048
`endif

module tb_reverb_config_sequencer;

  localparam int MAXD = `MAX_FILTER_FIFO_LENGTH;

  logic               clk = 1'b0;
  logic               rstn;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [3:0]         cfg_addr;
  logic signed [31:0] cfg_data;
  logic               commit;
  logic               sample_tick;
  logic               err_clear;
  logic signed [31:0] tau_o  [6];
  logic signed [31:0] gain_o [7];
  logic               write;
  logic               busy;
  logic               err_clamp;
  logic               err_addr;
  logic               err_timeout;

  logic signed [31:0] exp_tau  [6];
  logic signed [31:0] exp_gain [7];

  int n_cmp  = 0;
  int n_fail = 0;
  int hi;

  always #5 clk = ~clk;

  reverb_config_sequencer #(
    .WIDTH(24),
    .MAXDELAY(MAXD),
`ifdef REVERB_CFG_TIMEOUT_EN
    .TIMEOUT_CYCLES(16),
`endif
    .WRITE_HOLD(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .commit(commit), .sample_tick(sample_tick), .err_clear(err_clear),
    .tau_out(tau_o), .gain_out(gain_o),
    .write(write), .busy(busy),
    .err_clamp(err_clamp), .err_addr(err_addr), .err_timeout(err_timeout)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 6; i++) check($sformatf("%s tau[%0d]", tag, i), tau_o[i], exp_tau[i]);
    for (int i = 0; i < 7; i++) check($sformatf("%s gain[%0d]", tag, i), gain_o[i], exp_gain[i]);
  endtask

  task automatic host_write(input logic [3:0] a, input logic signed [31:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_valid = 1'b0;
  endtask

  // Commit, idle for gap cycles, then tick; returns at the falling edge inside APPLY.
  task automatic commit_apply(input int gap);
    commit = 1'b1; step(); commit = 1'b0;
    repeat (gap) step();
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
  endtask

  // From APPLY, count write-high cycles until back in IDLE (bounded).
  task automatic finish_pulse(input string tag);
    hi = 0;
    for (int i = 0; i < 32 && busy; i++) begin
      if (write) hi++;
      step();
    end
    check({tag, " write cycles"}, hi, 4);
    check({tag, " idle"}, busy, 0);
  endtask

  initial begin
    rstn = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    commit = 1'b0; sample_tick = 1'b0; err_clear = 1'b0;
    for (int i = 0; i < 6; i++) exp_tau[i] = 1;
    for (int i = 0; i < 7; i++) exp_gain[i] = 0;
    repeat (2) step();

    // Reset state
    check_all("reset");
    check("reset write", write, 0);
    check("reset busy", busy, 0);
    check("reset ready", cfg_ready, 1);
    check("reset err_clamp", err_clamp, 0);
    check("reset err_addr", err_addr, 0);
    check("reset err_timeout", err_timeout, 0);
    rstn = 1'b1;
    step();

    // Write and commit in the same cycle; tick 10 cycles later
    cfg_valid = 1'b1; cfg_addr = 4'd6; cfg_data = 32'h0B3; commit = 1'b1;
    step();
    cfg_valid = 1'b0; commit = 1'b0;
    check("t1 busy", busy, 1);
    check("t1 ready", cfg_ready, 0);
    repeat (9) step();
    check("t1 pre-tick gain0", gain_o[0], 0);
    check("t1 pre-tick write", write, 0);
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    exp_gain[0] = 32'h0B3;
    check_all("t1 apply");
    check("t1 apply write", write, 0);
    step();
    check("t1 pulse write", write, 1);
    hi = 1;
    for (int i = 0; i < 32 && busy; i++) begin
      step();
      if (write) hi++;
    end
    check("t1 write cycles", hi, 4);
    check("t1 busy after", busy, 0);
    check("t1 err_clamp", err_clamp, 0);
    check("t1 err_addr", err_addr, 0);
    check("t1 err_timeout", err_timeout, 0);

    // Clamping above range, then err_clear
    host_write(4'd7, 32'h180);
    host_write(4'd0, MAXD + 5);
    check("t2 clamp flag", err_clamp, 1);
    host_write(4'd8, 32'h040);
    host_write(4'd1, 7);
    commit_apply(3);
    exp_gain[1] = 32'h100; exp_tau[0] = MAXD; exp_gain[2] = 32'h040; exp_tau[1] = 7;
    check_all("t2 apply");
    finish_pulse("t2");
    err_clear = 1'b1; step(); err_clear = 1'b0;
    check("t2 err_clear", err_clamp, 0);

    // Exact boundaries do not clamp; below-range values do
    host_write(4'd9, 32'h100);
    host_write(4'd2, MAXD);
    check("t2b boundary no clamp", err_clamp, 0);
    host_write(4'd8, -32'sd16);
    check("t2b negative gain clamp", err_clamp, 1);
    host_write(4'd1, 0);
    commit_apply(0);
    exp_gain[3] = 32'h100; exp_tau[2] = MAXD; exp_gain[2] = 0; exp_tau[1] = 1;
    check_all("t2b apply");
    finish_pulse("t2b");
    err_clear = 1'b1; step(); err_clear = 1'b0;

    // Illegal address: accepted, flagged, no bank change
    cfg_valid = 1'b1; cfg_addr = 4'd14; cfg_data = 32'h55;
    check("t3 ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    check("t3 err_addr", err_addr, 1);
    check("t3 busy", busy, 0);
    check("t3 err_clamp", err_clamp, 0);
    commit_apply(1);
    check_all("t3 apply");
    finish_pulse("t3");
    err_clear = 1'b1; step(); err_clear = 1'b0;
    check("t3 err_addr clear", err_addr, 0);

    // Write+commit+tick together: that tick is ignored, the next one applies
    cfg_valid = 1'b1; cfg_addr = 4'd10; cfg_data = 32'h011; commit = 1'b1; sample_tick = 1'b1;
    step();
    cfg_valid = 1'b0; commit = 1'b0; sample_tick = 1'b0;
    step(); step();
    check("t4 still waiting", busy, 1);
    check("t4 gain4 old", gain_o[4], 0);
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    exp_gain[4] = 32'h011;
    check_all("t4 first apply");
    step();
    check("t4 first pulse", write, 1);
    // Commit during PULSE, host write held until the pending IDLE cycle opens cfg_ready
    commit = 1'b1; cfg_valid = 1'b1; cfg_addr = 4'd10; cfg_data = 32'h022;
    step();
    commit = 1'b0;
    for (int i = 0; i < 32 && !cfg_ready; i++) step();
    check("t4 ready pulse", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    check("t4 pending wait busy", busy, 1);
    check("t4 pending wait ready", cfg_ready, 0);
    check("t4 pending write low", write, 0);
    check("t4 gain4 held", gain_o[4], 32'h011);
    step(); step();
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    exp_gain[4] = 32'h022;
    check_all("t4 second apply");
    finish_pulse("t4");
    repeat (4) step();
    check("t4 no third pulse", busy, 0);

    // Asynchronous reset during PULSE
    host_write(4'd0, 50);
    commit_apply(0);
    step();
    check("t5 in pulse", write, 1);
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) exp_tau[i] = 1;
    for (int i = 0; i < 7; i++) exp_gain[i] = 0;
    check("t5 write drop", write, 0);
    check("t5 busy drop", busy, 0);
    check("t5 ready", cfg_ready, 1);
    check_all("t5 reset");
    step();
    rstn = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (write || busy) hi++;
    end
    check("t5 no pulse after release", hi, 0);
    commit_apply(0);
    check_all("t5 shadow reset");
    finish_pulse("t5");

    // WAIT_TICK without a tick
    commit = 1'b1; step(); commit = 1'b0;
`ifdef REVERB_CFG_TIMEOUT_EN
    repeat (15) step();
    check("t6 before timeout flag", err_timeout, 0);
    check("t6 before timeout busy", busy, 1);
    step();
    check("t6 timeout flag", err_timeout, 1);
    check("t6 apply write low", write, 0);
    step();
    check("t6 timeout pulse", write, 1);
    repeat (6) step();
    check("t6 idle", busy, 0);
`else
    repeat (40) step();
    check("t6 waits forever", busy, 1);
    check("t6 no timeout flag", err_timeout, 0);
    check("t6 no write", write, 0);
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    finish_pulse("t6");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reverb_config_sequencer.md
Name: reverb_config_sequencer

Overview:
- Owns the tau/gain configuration of reverberator_core (6 tau, 7 gain words).
- Host writes land in a shadow bank; a commit copies shadow to the active outputs on a sample-tick boundary, then issues a clean write pulse.
- Range-checks every value (gain in [0, 1.0], tau in [1, MAXDELAY]) so the core's gain assertion never fires.
- Sits between the host register interface and reverberator_core.

Parameters:
- WIDTH, 24, integer width; WORD = WIDTH + `FIXED_POINT.
- MAXDELAY, `MAX_FILTER_FIFO_LENGTH, largest legal tau in samples.
- WRITE_HOLD, 4, cycles the write output stays high (min 1).
- TIMEOUT_CYCLES, 4096, WAIT_TICK timeout; used only with REVERB_CFG_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_valid  in  1  host write request.
- cfg_ready  out  1  high only in IDLE.
- cfg_addr  in  4  0..5 select tau[0..5]; 6..12 select gain[0..6]; 13..15 illegal.
- cfg_data  in  WORD  signed value. tau is an integer sample count; gain is fixed-point.
- commit  in  1  one-cycle request to apply the shadow bank.
- sample_tick  in  1  one-cycle strobe per sample, synchronous to clk.
- err_clear  in  1  clears the sticky error flags.
- tau_out[6]  out  WORD  active tau array to the core.
- gain_out[7]  out  WORD  active gain array to the core.
- write  out  1  configuration update strobe to the core.
- busy  out  1  high in any state other than IDLE.
- err_clamp  out  1  sticky: a value was clamped.
- err_addr  out  1  sticky: an illegal address was written.
- err_timeout  out  1  sticky: timeout occurred; tied to 0 without the macro.

Behaviour:
- Reset (asynchronous, any state):
  - shadow and active tau = 1; shadow and active gain = 0.
  - write = 0, busy = 0, cfg_ready = 1, pending = 0, all err flags = 0, state = IDLE.
  - An in-flight commit is discarded.
- Handshake:
  - A write transfers when cfg_valid && cfg_ready.
  - Legal address: the clamped value goes to the shadow register on the same edge.
  - Illegal address: the data is discarded, err_addr sets, and the transfer still completes.
- Clamp rules (signed compare):
  - gain > (1 <<< `FIXED_POINT) → 1.0; gain < 0 → 0.
  - tau < 1 → 1; tau > MAXDELAY → MAXDELAY.
  - Any clamp sets err_clamp.
- State machine (IDLE, WAIT_TICK, APPLY, PULSE):
  - IDLE: commit → WAIT_TICK. A write and a commit in the same cycle: the write is stored first and is included in the commit.
  - WAIT_TICK: cfg_ready = 0. On sample_tick → APPLY. A tick coincident with the commit cycle is not used; the next tick is.
  - APPLY: one cycle. Active arrays load from shadow; write stays 0 so data is stable before write rises. Next state PULSE.
  - PULSE: write = 1 for exactly WRITE_HOLD cycles (down-counter), then IDLE with write = 0.
- Pending commit:
  - A commit received outside IDLE sets a 1-deep pending flag; further commits merge into it.
  - On entering IDLE with pending set: go directly to WAIT_TICK next cycle and clear pending. cfg_ready still pulses high for that one IDLE cycle.
- Output timing:
  - Active outputs change only in APPLY.
  - Latency from commit to write rising: ticks-to-wait + 2 cycles minimum (commit→WAIT_TICK, tick→APPLY, APPLY→PULSE).
- err_clear clears all flags. If err_clear coincides with a new error event, the set wins.

Optional Feature:
- Macro: REVERB_CFG_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_TICK.
  - After TIMEOUT_CYCLES cycles with no sample_tick, go to APPLY anyway and set err_timeout.
  - The counter clears on leaving WAIT_TICK.
- Undefined:
  - WAIT_TICK waits indefinitely.
  - err_timeout is constant 0 and no counter logic is built.

Test Plan (`FIXED_POINT = 8):
- Reset, then write addr 6 = 0x0B3 and commit; tick 10 cycles later → gain_out[0] = 0x0B3 one cycle after tick, write high 4 cycles, busy low after; no err flags.
- Write addr 7 = 0x180 and addr 0 = MAXDELAY+5, commit → gain_out[1] = 0x100, tau_out[0] = MAXDELAY, err_clamp = 1; err_clear → 0.
- Write addr 14 = 0x55 → accepted with cfg_ready high, err_addr = 1, no shadow change visible after commit.
- Commit, then second commit during PULSE with a new shadow value loaded beforehand → two write pulses; second delivers new value on the next tick after return to IDLE.
- Assert rstn low during PULSE → write, busy drop immediately (asynchronously); outputs return to tau = 1 / gain = 0; no further pulse after release.
- With REVERB_CFG_TIMEOUT_EN, TIMEOUT_CYCLES = 16, commit with no tick → APPLY after 16 cycles, err_timeout = 1, write pulse issued.
